mdu: RTL and testbench
======================

# mdu

Multi-cycle multiply/divide unit in the Execute stage of the five-stage pipeline. It owns the HI/LO registers and executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It produces the `start`/`busy` pair that the hazard unit consumes: the hazard unit stalls Decode whenever an MD-class instruction is pending while `start || busy`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu start; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu start; legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `en`  in  1  valid E-stage MD instruction this cycle; already gated by the pipeline, low for flushed bubbles.
- `op`  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; codes 9..15 are treated as none.
- `a`  in  32  rs operand (already forwarded).
- `b`  in  32  rt operand (already forwarded).
- `start`  out  1  combinational; high when `en` is set, op is 1..4, and `busy` is 0.
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `rdata`  out  32  combinational; equals `hi` when op is 7, `lo` when op is 8, otherwise 0.

## Operation
- On a `start` cycle the unit computes the result from `a`/`b` and loads it into a pending pair, `phi`/`plo`. It loads the counter `cnt` (4 bits) with `MULT_CYCLES` or `DIV_CYCLES`. At the same edge `busy` rises.
- While `cnt` is not 0, `cnt` decrements at each edge. At the edge where `cnt` goes from 1 to 0, the unit copies `phi`/`plo` into `hi`/`lo` and `busy` falls.
- `busy` equals (`cnt` != 0).
- mult: signed 64-bit product of `a` and `b`; `hi` receives product[63:32] and `lo` receives product[31:0].
- multu: as mult, with both operands unsigned.
- div: signed division.
  - `lo` receives the quotient, truncated toward zero.
  - `hi` receives the remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000 and `hi` = 0.
- divu: unsigned division; `lo` receives the quotient and `hi` the remainder.
- Divide by zero (`b` = 0, div or divu):
  - `busy` still runs for the full `DIV_CYCLES`.
  - At completion `hi`/`lo` keep their previous values; no write occurs.
- mthi / mtlo: when `en` is set and `busy` is 0, `hi` or `lo` takes `a` at the edge. Single-cycle; `start` stays low.
- mfhi / mflo: read only. `rdata` reflects the current `hi`/`lo`, including a value written at the immediately preceding edge.
- Any op arriving with `en` high while `busy` is 1 is ignored entirely: no state change, `start` stays low. The hazard unit prevents this case; the MDU must still tolerate it.
- A start in the cycle right after completion (`busy` just fell) is legal. It starts a new operation using the freshly committed `hi`/`lo`.
- `en` low or op = 0: no state change.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `cnt` = 0, `busy` = 0, `phi` = 0, `plo` = 0. Consequently `start` = 0 and `rdata` = 0 unless `en` is set with op 7 or 8.
- Reset asserted mid-operation aborts the operation. Pending results are discarded, `hi`/`lo` are cleared, and `busy` is 0 on the next cycle.
- Start in cycle T gives:
  - `busy` high for cycles T+1 through T+N.
  - New `hi`/`lo` visible from cycle T+N+1.
  - `busy` low in cycle T+N+1.
- The hazard unit observes `start || busy` high for N+1 consecutive cycles, T through T+N.
- mthi/mtlo in cycle T makes the new value visible from cycle T+1.
- Only the 64-bit multiply and divide operators sit between the operand inputs and the pending registers. These paths may be implemented iteratively, provided completion still occurs exactly at T+N+1.

## Test plan
- mult with a = 0xFFFFFFFD (-3), b = 5:
  - `start` high at T.
  - `busy` high at T+1..T+5.
  - `hi` = 0xFFFFFFFF and `lo` = 0xFFFFFFF1 at T+6.
- divu with a = 100, b = 7: `busy` is high for 10 cycles, then `lo` = 14 and `hi` = 2.
- div with a = 0xFFFFFFF9 (-7), b = 2: `lo` = 0xFFFFFFFD and `hi` = 0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000 and `hi` = 0.
- Divide by zero:
  - Sequence: mthi 0x11, mtlo 0x22, then div with b = 0.
  - `busy` runs for 10 cycles.
  - `hi` = 0x11 and `lo` = 0x22 afterwards.
- mult in flight: multu 0xFFFFFFFF × 2 started, then mtlo 0x55 issued at T+2, then reset asserted at T+3:
  - The mtlo is ignored.
  - After reset, `busy` = 0 and `hi` = `lo` = 0.
  - mflo in the following cycle gives `rdata` = 0.

Source files
------------

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO registers.
// Executes mult, multu, div, divu (multi-cycle, result committed at the end
// of the busy window) and mthi, mtlo, mfhi, mflo (single-cycle).
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   en, op[3:0]         valid E-stage MD instruction and its operation code
//   a[31:0], b[31:0]    rs / rt operands
//   start               combinational: a mult/div is accepted this cycle
//   busy                registered: an operation is in flight
//   hi[31:0], lo[31:0]  HI / LO registers
//   rdata[31:0]         combinational: hi for mfhi, lo for mflo, else 0
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_e;

  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]  phi_q, phi_d, plo_q, plo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwr_q, pwr_d;   // pending result should be committed
  logic          busy_q, busy_d;

  // Arithmetic datapath
  logic [2*W-1:0] prod_s, prod_u;
  logic [W-1:0]   divu_den, quo_u, rem_u;
  logic [W-1:0]   a_mag, b_mag, divs_den, quo_m, rem_m, quo_s, rem_s;
  logic           is_md;

  assign prod_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // Zero divisor is replaced by 1 so the divider never sees it; the result
  // is dropped anyway via pwr.
  assign divu_den = (b == '0) ? W'(1) : b;
  assign quo_u    = a / divu_den;
  assign rem_u    = a % divu_den;

  // Signed divide on magnitudes; 0x80000000 maps to itself, which gives the
  // wrapped quotient 0x80000000 for 0x80000000 / -1.
  assign a_mag    = a[W-1] ? (W'(0) - a) : a;
  assign b_mag    = b[W-1] ? (W'(0) - b) : b;
  assign divs_den = (b_mag == '0) ? W'(1) : b_mag;
  assign quo_m    = a_mag / divs_den;
  assign rem_m    = a_mag % divs_den;
  assign quo_s    = (a[W-1] ^ b[W-1]) ? (W'(0) - quo_m) : quo_m;
  assign rem_s    = a[W-1] ? (W'(0) - rem_m) : rem_m;

  assign is_md = (op == OP_MULT) || (op == OP_MULTU) ||
                 (op == OP_DIV)  || (op == OP_DIVU);

  // Next-state and combinational outputs
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    cnt_d  = cnt_q;
    pwr_d  = pwr_q;
    start  = en && is_md && !busy_q;
    rdata  = '0;

    if (start) begin
      case (op)
        OP_MULT: begin
          phi_d = prod_s[2*W-1:W];
          plo_d = prod_s[W-1:0];
          pwr_d = 1'b1;
          cnt_d = CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          phi_d = prod_u[2*W-1:W];
          plo_d = prod_u[W-1:0];
          pwr_d = 1'b1;
          cnt_d = CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          phi_d = rem_s;
          plo_d = quo_s;
          pwr_d = (b != '0);
          cnt_d = CW'(DIV_CYCLES);
        end
        default: begin
          phi_d = rem_u;
          plo_d = quo_u;
          pwr_d = (b != '0);
          cnt_d = CW'(DIV_CYCLES);
        end
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && pwr_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (en) begin
      if (op == OP_MTHI) hi_d = a;
      if (op == OP_MTLO) lo_d = a;
    end

    busy_d = (cnt_d != '0);

    if (op == OP_MFHI)      rdata = hi_q;
    else if (op == OP_MFLO) rdata = lo_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      cnt_q  <= '0;
      pwr_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      cnt_q  <= cnt_d;
      pwr_q  <= pwr_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed test-plan steps followed by randomized traffic, checked
// against a cycle-numbered behavioural model of the HI/LO unit.
module tb_mdu;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        start, busy;
  logic [31:0] hi, lo, rdata;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .a(a), .b(b),
    .start(start), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  // Model state: architectural HI/LO plus one scheduled commit.
  logic [31:0] hi_m, lo_m, phi_m, plo_m;
  bit          wr_m, act_m;
  int          cyc, st_cyc, n_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result of a mult/div from plain 64-bit arithmetic.
  task automatic calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      output logic [31:0] h, output logic [31:0] l, output bit wr);
    longint sx, sy, p, q, r;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = '0; l = '0; wr = 1;
    case (o)
      4'd1: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      4'd2: begin up = {32'b0, x} * {32'b0, y}; h = up[63:32]; l = up[31:0]; end
      4'd3: begin
        if (y == 0) wr = 0;
        else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (y == 0) wr = 0;
        else begin l = x / y; h = x % y; end
      end
    endcase
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input bit rst, input bit e, input logic [3:0] o,
                      input logic [31:0] x, input logic [31:0] y);
    bit exp_start;
    logic [31:0] exp_rd;
    reset = rst; en = e; op = o; a = x; b = y;
    #1;
    exp_start = e && (o >= 4'd1) && (o <= 4'd4) && !act_m;
    exp_rd = (o == 4'd7) ? hi_m : (o == 4'd8) ? lo_m : 32'h0;
    if (chk_on) begin
      check("start", 32'(start), 32'(exp_start));
      check("busy",  32'(busy),  32'(act_m));
      check("hi",    hi, hi_m);
      check("lo",    lo, lo_m);
      check("rdata", rdata, exp_rd);
    end
    if (rst) begin
      hi_m = '0; lo_m = '0; act_m = 0;
    end else if (act_m) begin
      if (cyc == st_cyc + n_cyc) begin
        if (wr_m) begin hi_m = phi_m; lo_m = plo_m; end
        act_m = 0;
      end
    end else if (exp_start) begin
      calc(o, x, y, phi_m, plo_m, wr_m);
      act_m = 1; st_cyc = cyc;
      n_cyc = (o <= 4'd2) ? int'(MC) : int'(DC);
    end else if (e) begin
      if (o == 4'd5) hi_m = x;
      if (o == 4'd6) lo_m = x;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    hi_m = '0; lo_m = '0; phi_m = '0; plo_m = '0;
    wr_m = 0; act_m = 0; cyc = 0; st_cyc = 0; n_cyc = 0;
    step(1, 0, 4'd0, 32'h0, 32'h0);
    step(1, 0, 4'd0, 32'h0, 32'h0);
    chk_on = 1;

    // Reset state
    en = 1; op = 4'd7; #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    idle(1);

    // mult -3 * 5: busy T+1..T+5, result at T+6
    step(0, 1, 4'd1, 32'hFFFF_FFFD, 32'd5);
    idle(5);
    check("mult_busy_done", 32'(busy), 32'h0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    // divu 100 / 7
    step(0, 1, 4'd4, 32'd100, 32'd7);
    idle(10);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // div -7 / 2
    step(0, 1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // div overflow case
    step(0, 1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    check("divov_lo", lo, 32'h8000_0000);
    check("divov_hi", hi, 32'h0);

    // divide by zero keeps previous HI/LO; mfhi sees the preceding write
    step(0, 1, 4'd5, 32'h11, 32'h0);
    step(0, 1, 4'd7, 32'h0, 32'h0);
    step(0, 1, 4'd6, 32'h22, 32'h0);
    step(0, 1, 4'd3, 32'd9, 32'h0);
    idle(10);
    check("dbz_hi", hi, 32'h11);
    check("dbz_lo", lo, 32'h22);

    // back-to-back: start right after completion uses committed values
    step(0, 1, 4'd2, 32'd6, 32'd7);
    idle(5);
    step(0, 1, 4'd4, 32'd45, 32'd4);
    idle(10);
    check("b2b_lo", lo, 32'd11);
    check("b2b_hi", hi, 32'd1);

    // in-flight multu, mtlo ignored while busy, then reset aborts
    step(0, 1, 4'd2, 32'hFFFF_FFFF, 32'd2);
    idle(1);
    step(0, 1, 4'd6, 32'h55, 32'h0);
    step(1, 0, 4'd0, 32'h0, 32'h0);
    en = 1; op = 4'd8; #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    step(0, 1, 4'd8, 32'h0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           (($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                        : 4'($urandom_range(0, 8))),
           pick(), pick());
    end
    idle(DC + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
